// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, reset PC and the bubble instruction.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Logical immediates take a zero-extended operand; everything else sign-extends.
  function automatic logic is_zero_ext_op(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) ||
           (opcode == OP_XORI) || (opcode == OP_LUI);
  endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with next-PC priority: reset, branch redirect, stall hold, sequential.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];
  assign pc_plus4 = pc + 32'd4;

  // A taken branch overrides stall so the redirect is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= {branch_target[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register, with decode field slicing and
// the extender select for the downstream immediate unit.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic        zero_or_sign
);

  logic [31:0] pc_plus4;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (imem_addr),
    .pc_plus4      (pc_plus4)
  );

  // Flush inserts a bubble even while stalled; the wrong-path word is discarded.
  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'h0;
    end else if (!stall) begin
      id_valid    <= 1'b1;
      id_instr    <= imem_rdata;
      id_pc_plus4 <= pc_plus4;
    end
  end

  assign id_opcode    = id_instr[31:26];
  assign id_rs        = id_instr[25:21];
  assign id_rt        = id_instr[20:16];
  assign id_rd        = id_instr[15:11];
  assign id_funct     = id_instr[5:0];
  assign sa           = id_instr[10:6];
  assign imm          = id_instr[15:0];
  assign zero_or_sign = ~is_zero_ext_op(id_opcode);

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, then random
// control traffic against a behavioural fetch/IF-ID model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_rdata, tb_rdata;
  logic        id_valid, zero_or_sign;
  logic [31:0] id_instr, id_pc_plus4;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, sa;
  logic [15:0] imm;
  logic        use_model_mem = 1'b0;

  int checks   = 0;
  int failures = 0;

  if_id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_opcode     (id_opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_funct      (id_funct),
    .sa            (sa),
    .imm           (imm),
    .zero_or_sign  (zero_or_sign)
  );

  always #5 clk = ~clk;

  // Address-dependent memory contents; opcode sweeps 0x0A..0x11 to hit the logical immediates.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B9) ^ (a >> 7);
    return {6'h0A + {3'b000, a[4:2]}, h[25:0]};
  endfunction

  assign imem_rdata = use_model_mem ? mem_word(imem_addr) : tb_rdata;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[15];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] tgt, input logic [31:0] rd);
    @(negedge clk);
    rst = r; stall = s; branch_taken = b; branch_target = tgt; tb_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_instr, input logic [31:0] e_pc4);
    logic [5:0] op;
    logic       e_zos;
    op    = e_instr[31:26];
    e_zos = !(op >= 6'h0C && op <= 6'h0F);
    cmp({name, " imem_addr"},   imem_addr,   e_addr);
    cmp({name, " id_valid"},    {31'b0, id_valid}, {31'b0, e_valid});
    cmp({name, " id_instr"},    id_instr,    e_instr);
    cmp({name, " id_pc_plus4"}, id_pc_plus4, e_pc4);
    cmp({name, " fields"},
        {id_opcode, id_rs, id_rt, id_rd, id_funct},
        {e_instr[31:26], e_instr[25:21], e_instr[20:16], e_instr[15:11], e_instr[5:0]});
    cmp({name, " sa_imm"}, {11'b0, sa, imm}, {11'b0, e_instr[10:6], e_instr[15:0]});
    cmp({name, " zero_or_sign"}, {31'b0, zero_or_sign}, {31'b0, e_zos});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; tb_rdata = '0;

    //             rst   stall br    target         rdata          addr           v     instr          pc4
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hAAAA_AAAA, 32'h0040_0000, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h2008_FFFF, 32'h0040_0004, 1'b1, 32'h2008_FFFF, 32'h0040_0004};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0040_0004, 1'b1, 32'h2008_FFFF, 32'h0040_0004};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0040_0004, 1'b1, 32'h2008_FFFF, 32'h0040_0004};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0040_0004, 1'b1, 32'h2008_FFFF, 32'h0040_0004};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3408_8000, 32'h0040_0008, 1'b1, 32'h3408_8000, 32'h0040_0008};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0140, 32'h0040_000C, 1'b1, 32'h0000_0140, 32'h0040_000C};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0103, 32'h1234_5678, 32'h0040_0100, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3C01_1234, 32'h0040_0104, 1'b1, 32'h3C01_1234, 32'h0040_0104};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0040_0200, 32'h1111_1111, 32'h0040_0200, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h2108_0001, 32'h0040_0200, 1'b0, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h2108_0001, 32'h0040_0000, 1'b0, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2222_2222, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3908_00FF, 32'h0000_0000, 1'b1, 32'h3908_00FF, 32'h0000_0000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3108_0F0F, 32'h0000_0004, 1'b1, 32'h3108_0F0F, 32'h0000_0004};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].target, vecs[i].rdata);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_valid,
                  vecs[i].exp_instr, vecs[i].exp_pc4);
    end

    // Spot checks on the extender inputs called out for particular encodings
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h2008_FFFF);
    cmp("addi sa", {27'b0, sa}, 32'h1F);
    cmp("addi imm", {16'b0, imm}, 32'hFFFF);
    cmp("addi zero_or_sign", {31'b0, zero_or_sign}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h3408_8000);
    cmp("ori zero_or_sign", {31'b0, zero_or_sign}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0140);
    cmp("sll sa", {27'b0, sa}, 32'd5);

    // Random control traffic against the behavioural model
    use_model_mem = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    m_pc = 32'h0040_0000; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    checkOutput("rand_reset", m_pc, m_valid, m_instr, m_pc4);

    for (int n = 0; n < 400; n++) begin
      logic r, s, b;
      logic [31:0] t, fetched;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = $urandom;
      fetched = mem_word(m_pc);
      if (r) begin
        m_pc = 32'h0040_0000; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      end else if (b) begin
        m_pc = t & ~32'd3; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      end else if (!s) begin
        m_valid = 1'b1; m_instr = fetched; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end
      applyStimulus(r, s, b, t, 32'h0);
      checkOutput($sformatf("rand%0d", n), m_pc, m_valid, m_instr, m_pc4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch stage and IF/ID pipeline register of the MIPS pipeline. It holds the PC and drives the instruction-memory address. It latches the fetched word into the IF/ID register, honouring stall and branch-flush. Combinationally from the registered instruction it drives the decode fields, including the shamt/immediate/extension-select inputs of the downstream immediate extender.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word placed in IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  from hazard unit; hold PC and IF/ID contents.
- branch_taken  in  1  from EX/ID branch resolution; redirect PC and flush IF/ID.
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 2'b00).
- imem_addr  out  32  instruction-memory address, equal to the PC register.
- imem_rdata  in  32  combinational instruction-memory read data for imem_addr.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- id_instr  out  32  registered instruction.
- id_pc_plus4  out  32  registered PC+4 of that instruction.
- id_opcode  out  6  id_instr[31:26].
- id_rs  out  5  id_instr[25:21].
- id_rt  out  5  id_instr[20:16].
- id_rd  out  5  id_instr[15:11].
- id_funct  out  6  id_instr[5:0].
- sa  out  5  id_instr[10:6], to extender shamt input.
- imm  out  16  id_instr[15:0], to extender immediate input.
- zero_or_sign  out  1  extender select; 1 = sign-extend, 0 = zero-extend.

## Operation
- PC next-value priority on each edge: rst → RESET_PC; else branch_taken → {branch_target[31:2],2'b00}; else stall → hold; else PC+4.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID priority on each edge: rst → id_valid=0, id_instr=NOP_INSTR, id_pc_plus4=0.
- Else branch_taken → id_valid=0, id_instr=NOP_INSTR, id_pc_plus4=0. Flush wins over stall.
- Else stall → hold all IF/ID registers.
- Else capture: id_instr=imem_rdata, id_pc_plus4=PC+4, id_valid=1.
- Field outputs are pure combinational slices of id_instr. No extra register.
- zero_or_sign = 0 when id_opcode is ANDI (6'h0C), ORI (6'h0D), XORI (6'h0E) or LUI (6'h0F); 1 for every other opcode, including R-type and bubbles.

## Timing
- One-cycle fetch latency: the word at imem_addr in cycle n appears on id_instr in cycle n+1.
- Reset values (after the reset edge): imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc_plus4=0, all fields 0, zero_or_sign=1.
- rst asserted mid-stream overrides stall and branch_taken in the same cycle.
- Branch redirect: the edge with branch_taken=1 loads the target and flushes. The next cycle fetches the target. The target instruction reaches ID one cycle later, giving one bubble.
- Stall held for k cycles: PC and IF/ID are frozen for exactly k edges. imem_rdata is ignored during those edges.
- Stall and branch_taken together: the redirect and flush take effect; stall is ignored.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE);
  - the NOP_INSTR default;
  - the RESET_PC default.
- One sub-module: pc_reg, covering the PC register and the next-PC priority mux.
- The IF/ID register, field slicing and zero_or_sign decode live in the top level.

## Test plan
- Reset then free-run with imem returning addr-dependent words: imem_addr steps 0x0040_0000, …04, …08. id_instr lags one cycle. id_pc_plus4 = addr+4. id_valid rises one cycle after reset release.
- Stall held 3 cycles while id_instr=32'h2008_FFFF (addi): PC and id_instr are unchanged for 3 edges. sa=5'h1F, imm=16'hFFFF, zero_or_sign=1. Fetch resumes at the held PC.
- id_instr=32'h3408_8000 (ori): zero_or_sign=0 and imm=16'h8000. id_instr=32'h0000_0140 (sll, shamt 5): sa=5'd5, zero_or_sign=1.
- branch_taken with branch_target=32'h0040_0103: next imem_addr=0x0040_0100. Next id_valid=0 and id_instr=0. The target word appears in ID the following cycle.
- branch_taken and stall asserted together: redirect and flush occur. Separately, rst asserted mid-stall: PC=RESET_PC and id_valid=0.
- PC preloaded via branch to 0xFFFF_FFFC, then free-run: next imem_addr=0x0000_0000 and id_pc_plus4=0x0000_0000.
